// File: rtl/cpu_pkg.sv
// Shared core definitions: sequencer states, architectural constants, register-compare helper.
package cpu_pkg;

   typedef enum logic [1:0] {
      RUN,
      REDIR,
      DWAIT
   } hz_state_e;

   localparam logic [4:0]  REG_ZERO = 5'd0;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   // True when a used source register matches a real (non-$0) destination.
   function automatic logic src_hit(input logic used, input logic [4:0] src,
                                    input logic [4:0] dst);
      return used && (src == dst) && (dst != REG_ZERO);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Count up on inc, stick at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: resolves load-use, redirect, mult/div, imem and dmem hazards and
// drives the PC / IF2ID / ID2EX controls plus stall and flush performance counters.
module hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned REDIR_CYC = 1,
   parameter int unsigned MD_LAT    = 32,
   parameter int unsigned PERF_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_md_op,
   input  logic              id_md_rd,
   input  logic              ex_memread,
   input  logic [4:0]        ex_rt,
   input  logic              br_taken,
   input  logic              imem_ready,
   input  logic              dmem_ready,
   input  logic              mem_req,
   output logic              wr_pc,
   output logic              wr_IF2ID,
   output logic              flush_IF2ID,
   output logic              flush_ID2EX,
   output logic              freeze_back,
   output logic              md_busy,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt
);

   hz_state_e  state_q;
   hz_state_e  resume_q;
   hz_state_e  eff_state;
   logic       pending_q;
   logic [1:0] redir_cnt_q;
   logic [5:0] md_cnt_q;

   logic dwait;
   logic new_br;
   logic redirect;
   logic load_use;
   logic md_hz;
   logic md_issue;

   // Hazard detection; in DWAIT the state we will resume into decides redirect.
   always_comb begin
      eff_state = (state_q == DWAIT) ? resume_q : state_q;
      dwait     = mem_req && !dmem_ready;
      new_br    = br_taken || pending_q;
      redirect  = new_br || (eff_state == REDIR);
      load_use  = ex_memread && (src_hit(id_use_rs, id_rs, ex_rt) ||
                                 src_hit(id_use_rt, id_rt, ex_rt));
      md_busy   = (md_cnt_q != 6'd0);
      md_hz     = md_busy && (id_md_op || id_md_rd);
      md_issue  = id_md_op && !dwait && !redirect && !load_use && !md_hz;
   end

   // Prioritised pipeline controls; everything held low while in reset.
   always_comb begin
      wr_pc       = 1'b1;
      wr_IF2ID    = 1'b1;
      flush_IF2ID = 1'b0;
      flush_ID2EX = 1'b0;
      freeze_back = 1'b0;
      if (reset) begin
         wr_pc    = 1'b0;
         wr_IF2ID = 1'b0;
      end else if (dwait) begin
         wr_pc       = 1'b0;
         wr_IF2ID    = 1'b0;
         freeze_back = 1'b1;
      end else if (redirect) begin
         flush_IF2ID = 1'b1;
         flush_ID2EX = new_br;
      end else if (load_use || md_hz) begin
         wr_pc       = 1'b0;
         wr_IF2ID    = 1'b0;
         flush_ID2EX = 1'b1;
      end else if (!imem_ready) begin
         wr_pc       = 1'b0;
         flush_IF2ID = 1'b1;
      end
   end

   // Sequencer FSM, branch-pending bit, redirect countdown and mult/div occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         resume_q    <= RUN;
         pending_q   <= 1'b0;
         redir_cnt_q <= 2'd0;
         md_cnt_q    <= 6'd0;
      end else if (dwait) begin
         // Freeze everything; remember a branch that resolved during the wait.
         pending_q <= pending_q || br_taken;
         if (state_q != DWAIT) begin
            resume_q <= state_q;
         end
         state_q <= DWAIT;
      end else begin
         pending_q <= 1'b0;
         if (new_br) begin
            if (REDIR_CYC > 1) begin
               state_q     <= REDIR;
               redir_cnt_q <= 2'(REDIR_CYC - 1);
            end else begin
               state_q <= RUN;
            end
         end else if (eff_state == REDIR) begin
            if (redir_cnt_q <= 2'd1) begin
               state_q     <= RUN;
               redir_cnt_q <= 2'd0;
            end else begin
               state_q     <= REDIR;
               redir_cnt_q <= redir_cnt_q - 2'd1;
            end
         end else begin
            state_q <= RUN;
         end
         if (md_issue) begin
            md_cnt_q <= 6'(MD_LAT);
         end else if (md_busy) begin
            md_cnt_q <= md_cnt_q - 6'd1;
         end
      end
   end

   sat_counter #(
      .WIDTH (PERF_W)
   ) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (1'b0),
      .inc   (!wr_pc),
      .count (stall_cnt)
   );

   sat_counter #(
      .WIDTH (PERF_W)
   ) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (1'b0),
      .inc   (flush_IF2ID),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: single-cycle vector table, directed multi-cycle
// sequences and random stimulus against a rule-level reference model.
module tb_hazard_ctrl;

   localparam int unsigned RC = 2;
   localparam int unsigned ML = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_use_rs, id_use_rt, id_md_op, id_md_rd, ex_memread;
   logic       br_taken, imem_ready, dmem_ready, mem_req;

   logic        wr_pc, wr_IF2ID, flush_IF2ID, flush_ID2EX, freeze_back, md_busy;
   logic [31:0] stall_cnt, flush_cnt;
   logic        s_wr_pc, s_wr_IF2ID, s_flush_IF2ID, s_flush_ID2EX, s_freeze_back, s_md_busy;
   logic [2:0]  s_stall_cnt, s_flush_cnt;

   wire [5:0] outv = {wr_pc, wr_IF2ID, flush_IF2ID, flush_ID2EX, freeze_back, md_busy};

   always #5 clk = ~clk;

   hazard_ctrl #(.REDIR_CYC(RC), .MD_LAT(ML), .PERF_W(32)) dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
      .id_use_rt(id_use_rt), .id_md_op(id_md_op), .id_md_rd(id_md_rd),
      .ex_memread(ex_memread), .ex_rt(ex_rt), .br_taken(br_taken), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .mem_req(mem_req), .wr_pc(wr_pc), .wr_IF2ID(wr_IF2ID),
      .flush_IF2ID(flush_IF2ID), .flush_ID2EX(flush_ID2EX), .freeze_back(freeze_back),
      .md_busy(md_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Narrow-counter instance to observe saturation.
   hazard_ctrl #(.PERF_W(3)) dut_s (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
      .id_use_rt(id_use_rt), .id_md_op(id_md_op), .id_md_rd(id_md_rd),
      .ex_memread(ex_memread), .ex_rt(ex_rt), .br_taken(br_taken), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .mem_req(mem_req), .wr_pc(s_wr_pc), .wr_IF2ID(s_wr_IF2ID),
      .flush_IF2ID(s_flush_IF2ID), .flush_ID2EX(s_flush_ID2EX), .freeze_back(s_freeze_back),
      .md_busy(s_md_busy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: outstanding work expressed as plain counts.
   bit m_pending;
   int m_redir_left;
   int m_md_left;
   int m_stall, m_flush;
   bit e_wr_pc, e_wr_if, e_fl_if, e_fl_id, e_frz, e_busy, e_issue, e_dw, e_brn;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       use_rs;
      logic       use_rt;
      logic       memread;
      logic [4:0] ert;
      logic       br;
      logic       imem;
      logic       dmem;
      logic       req;
      logic [4:0] exp;  // {wr_pc, wr_IF2ID, flush_IF2ID, flush_ID2EX, freeze_back}
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic benign();
      id_rs = 0; id_rt = 0; ex_rt = 0;
      id_use_rs = 0; id_use_rt = 0; id_md_op = 0; id_md_rd = 0; ex_memread = 0;
      br_taken = 0; imem_ready = 1; dmem_ready = 1; mem_req = 0;
   endtask

   task automatic model_clear();
      m_pending = 0; m_redir_left = 0; m_md_left = 0; m_stall = 0; m_flush = 0;
   endtask

   task automatic model_eval();
      bit lu, mh, redir;
      lu = ex_memread && (ex_rt != 0) &&
           ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
      e_busy = (m_md_left != 0);
      mh = e_busy && (id_md_op || id_md_rd);
      e_dw = mem_req && !dmem_ready;
      e_brn = br_taken || m_pending;
      redir = e_brn || (m_redir_left > 0);
      {e_wr_pc, e_wr_if, e_fl_if, e_fl_id, e_frz} = 5'b11000;
      if (e_dw) {e_wr_pc, e_wr_if, e_frz} = 3'b001;
      else if (redir) begin e_fl_if = 1; e_fl_id = e_brn; end
      else if (lu || mh) {e_wr_pc, e_wr_if, e_fl_id} = 3'b001;
      else if (!imem_ready) {e_wr_pc, e_fl_if} = 2'b01;
      e_issue = id_md_op && !e_dw && !redir && !lu && !mh;
   endtask

   task automatic model_step();
      if (!e_wr_pc) m_stall++;
      if (e_fl_if) m_flush++;
      if (e_dw) begin
         m_pending = m_pending || br_taken;
      end else begin
         m_pending = 0;
         if (e_brn) m_redir_left = RC - 1;
         else if (m_redir_left > 0) m_redir_left--;
         if (e_issue) m_md_left = ML;
         else if (m_md_left > 0) m_md_left--;
      end
   endtask

   // Inputs already driven just after a posedge; compare mid-cycle, then clock.
   task automatic cycle(input string tag, output logic stalled);
      #2;
      model_eval();
      check({tag, " outputs"}, 32'(outv),
            32'({e_wr_pc, e_wr_if, e_fl_if, e_fl_id, e_frz, e_busy}));
      check({tag, " stall_cnt"}, stall_cnt, 32'(m_stall));
      check({tag, " flush_cnt"}, flush_cnt, 32'(m_flush));
      stalled = flush_ID2EX && !wr_IF2ID;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      reset = 1;
      benign();
      model_clear();
      #2;
      check("reset outputs", 32'(outv), 32'd0);
      check("reset stall_cnt", stall_cnt, 32'd0);
      @(posedge clk);
      #1;
      reset = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic st;
      int n;
      benign();
      vecs[0]  = '{5'd8, 5'd0, 1, 0, 1, 5'd8, 0, 1, 1, 0, 5'b00010};  // load-use rs
      vecs[1]  = '{5'd0, 5'd9, 0, 1, 1, 5'd9, 0, 1, 1, 0, 5'b00010};  // load-use rt
      vecs[2]  = '{5'd0, 5'd9, 0, 0, 1, 5'd9, 0, 1, 1, 0, 5'b11000};  // rt not read
      vecs[3]  = '{5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 1, 1, 0, 5'b11000};  // load to $0
      vecs[4]  = '{5'd8, 5'd0, 1, 0, 0, 5'd8, 0, 1, 1, 0, 5'b11000};  // not a load
      vecs[5]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 1, 0, 5'b11110};  // branch
      vecs[6]  = '{5'd8, 5'd0, 1, 0, 1, 5'd8, 1, 1, 1, 0, 5'b11110};  // branch beats load-use
      vecs[7]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, 5'b01100};  // imem wait
      vecs[8]  = '{5'd8, 5'd0, 1, 0, 1, 5'd8, 0, 0, 1, 0, 5'b00010};  // load-use beats imem
      vecs[9]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1, 5'b00001};  // dmem wait
      vecs[10] = '{5'd8, 5'd0, 1, 0, 1, 5'd8, 1, 0, 0, 1, 5'b00001};  // dmem wait beats all
      vecs[11] = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 1, 5'b11000};  // dmem ready
      vecs[12] = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 5'b11000};  // dmem idle
      vecs[13] = '{5'd3, 5'd3, 1, 1, 1, 5'd4, 0, 1, 1, 0, 5'b11000};  // no reg match

      do_reset();
      for (int i = 0; i < 14; i++) begin
         do_reset();
         id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_use_rs = vecs[i].use_rs;
         id_use_rt = vecs[i].use_rt; ex_memread = vecs[i].memread; ex_rt = vecs[i].ert;
         br_taken = vecs[i].br; imem_ready = vecs[i].imem; dmem_ready = vecs[i].dmem;
         mem_req = vecs[i].req;
         #2;
         check($sformatf("vec%0d", i), 32'(outv[5:1]), 32'(vecs[i].exp));
         #1;
         cycle($sformatf("vec%0d model", i), st);
      end

      // Load-use: one stall cycle, then defaults.
      do_reset();
      ex_memread = 1; ex_rt = 8; id_rs = 8; id_use_rs = 1;
      cycle("lu stall", st);
      benign();
      cycle("lu after", st);
      check("lu stall_cnt", stall_cnt, 32'd1);

      // Branch with load-use, two flush cycles.
      do_reset();
      br_taken = 1; ex_memread = 1; ex_rt = 5; id_rt = 5; id_use_rt = 1;
      cycle("br first", st);
      benign();
      #2;
      check("br redir cycle", 32'(outv[5:1]), 32'(5'b11100));
      #1;
      cycle("br redir", st);
      cycle("br done", st);
      check("br flush_cnt", flush_cnt, 32'd2);

      // dmem wait with a branch held pending.
      do_reset();
      mem_req = 1; dmem_ready = 0; br_taken = 1;
      cycle("dw1", st);
      br_taken = 0;
      cycle("dw2", st);
      cycle("dw3", st);
      dmem_ready = 1;
      #2;
      check("dw release", 32'(outv[5:1]), 32'(5'b11110));
      #1;
      cycle("dw release model", st);
      mem_req = 0;
      cycle("dw redir", st);

      // Mult/div: div then mfhi two cycles later.
      do_reset();
      id_md_op = 1;
      cycle("md issue", st);
      id_md_op = 0;
      cycle("md gap", st);
      id_md_rd = 1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         cycle("md wait", st);
         if (!st) break;
         n++;
      end
      check("md stall cycles", 32'(n), 32'd3);
      benign();
      cycle("md idle", st);

      // Async reset mid-REDIR and mid-countdown.
      do_reset();
      id_md_op = 1;
      cycle("rst issue", st);
      id_md_op = 0; br_taken = 1;
      cycle("rst br", st);
      br_taken = 0;
      #3;
      reset = 1;
      #1;
      check("async reset outputs", 32'(outv), 32'd0);
      check("async reset flush_cnt", flush_cnt, 32'd0);
      model_clear();
      @(posedge clk);
      #1;
      reset = 0;
      cycle("post reset", st);
      cycle("post reset 2", st);

      // Counter saturation on the narrow instance.
      do_reset();
      imem_ready = 0;
      for (int i = 0; i < 10; i++) cycle("sat", st);
      check("sat stall_cnt", 32'(s_stall_cnt), 32'd7);
      check("sat flush_cnt", 32'(s_flush_cnt), 32'd7);

      // Random traffic.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         id_rs = 5'($urandom_range(0, 3));
         id_rt = 5'($urandom_range(0, 3));
         ex_rt = 5'($urandom_range(0, 3));
         id_use_rs = 1'($urandom_range(0, 1));
         id_use_rt = 1'($urandom_range(0, 1));
         ex_memread = ($urandom_range(0, 3) == 0);
         id_md_op = ($urandom_range(0, 7) == 0);
         id_md_rd = ($urandom_range(0, 5) == 0);
         br_taken = ($urandom_range(0, 9) == 0);
         imem_ready = ($urandom_range(0, 4) != 0);
         mem_req = ($urandom_range(0, 3) == 0);
         dmem_ready = 1'($urandom_range(0, 1));
         cycle("rand", st);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
